mips_rtype_exec: RTL and testbench
==================================

# mips_rtype_exec

Parametrised, sequential execute/write-back unit for MIPS R-type instructions. It succeeds the standalone ALU, ALU-control and read-only register file with a single block. The block accepts one 32-bit instruction word per valid/ready handshake, reads a writable register file, executes an extended ALU operation set including shifts and an iterative unsigned multiply into HI/LO, and commits the result. It sits between instruction fetch/IR and the future memory stage.

## Interface
Parameters:
- XLEN, 32: datapath and register width.
- NREGS, 32: register count. Must be a power of two, at most 32. Address width AW = $clog2(NREGS).

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ins_valid  in  1  instruction word present.
- ins_ready  out  1  unit idle, can accept. Equal to (state == IDLE).
- ins_word  in  32  MIPS instruction: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
- done  out  1  one-cycle pulse when an instruction retires.
- wb_we  out  1  valid with done: a register-file write occurred.
- wb_addr  out  AW  destination register.
- wb_data  out  XLEN  value written.
- ovf  out  1  valid with done: ADD/SUB signed overflow, write suppressed.
- illegal  out  1  valid with done: unsupported op/funct, no state change.
- hi, lo  out  XLEN  HI/LO registers.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  combinational read of REGS[dbg_addr].

## Operation
- Register 0 reads as 0 and ignores writes.
- Address fields wider than AW are truncated to their low AW bits.
- An op field other than 0 is illegal.
- Supported funct codes:
  - 32 ADD, 33 ADDU, 34 SUB, 35 SUBU.
  - 36 AND, 37 OR, 38 XOR, 39 NOR.
  - 42 SLT (signed), 43 SLTU.
  - 0 SLL, 2 SRL, 3 SRA: shift rt by shamt, taken modulo XLEN.
  - 25 MULTU: {hi,lo} = rs*rt, 2*XLEN-bit unsigned product.
  - 16 MFHI, 18 MFLO: rd = hi or lo.
  - Any other funct is illegal.
- Arithmetic:
  - Results are truncated to XLEN bits.
  - ADD/SUB overflow occurs when the operand signs require it and the result sign differs. On overflow: ovf=1, wb_we=0, rd unchanged.
  - ADDU/SUBU never flag overflow.
- FSM states: IDLE, EXEC, MUL, WB.
  - IDLE → EXEC on ins_valid && ins_ready. The instruction word is latched on this edge.
  - EXEC: operands are read from REGS and the result and flags are registered. Next state is MUL for MULTU, otherwise WB.
  - MUL: shift-add, one bit per cycle, for exactly XLEN cycles, then WB.
  - WB: done=1. Commit the REGS write, or for MULTU the hi/lo update. Then go to IDLE.
- An instruction with rd=0 retires with wb_we=1, wb_addr=0, and REGS[0] stays 0.
- MULTU retires with wb_we=0.

## Timing
- Accept on edge k:
  - EXEC during cycle k+1.
  - WB (done=1) during k+2. The write is visible on dbg_data from k+3.
  - IDLE / ins_ready=1 in k+3.
  - Simple-op latency is 2 cycles. Throughput is 1 instruction per 3 cycles.
- MULTU: done during cycle k+2+XLEN. hi/lo update at the end of that cycle.
- ins_word is sampled only at acceptance. Later changes on ins_word are ignored.
- Back-to-back dependent instructions need no forwarding: the write commits before the next EXEC.
- Reset (asynchronous, any state, including mid-MUL):
  - state=IDLE, ins_ready=1.
  - done=wb_we=ovf=illegal=0, wb_addr=0, wb_data=0.
  - hi=lo=0, all REGS=0.
  - An in-flight instruction is discarded.
- done, wb_* and the flags are registered outputs, held at 0 outside WB.

## Structure
- Package mips_exec_pkg holds:
  - funct code localparams.
  - op-field constant for R-type (0).
  - state enum {IDLE, EXEC, MUL, WB}.
  - internal ALU-op enum.
- Sub-module mips_mult_seq: iterative XLEN-cycle unsigned multiplier.
  - Handshake: start/busy/done.
  - Output: 2*XLEN product.
  - Instantiated once and driven from the MUL state.
- The register file and ALU case logic stay inline.

## Test plan
- Reset, then dbg-load via a sequence of ADDU with known sources. Seed values: r1=3, r2=4. ADD r3=r1+r2 → done at k+2, wb_addr=3, wb_data=7, ready back at k+3.
- ADD with r4=0x7FFFFFFF, r5=1 → ovf=1, wb_we=0, r6 unchanged. Repeat with ADDU → r6=0x80000000, ovf=0.
- SLT vs SLTU with r1=0xFFFFFFFF, r2=1 → SLT gives 1, SLTU gives 0. SRA of 0x80000000 by 4 → 0xF8000000.
- MULTU with 0xFFFFFFFF × 0xFFFFFFFF → done at k+34, hi=0xFFFFFFFE, lo=0x00000001. MFHI r7 → r7=0xFFFFFFFE. ins_ready stays 0 throughout MUL.
- Write to rd=0 → dbg_data(0)=0. Funct 13 or op=8 → illegal=1, no register changes.
- Assert RESET mid-MUL at cycle k+10 → immediately ready=1, hi=lo=0, no done pulse. A new ADD afterwards completes normally.

Source files
------------

// File: rtl/mips_exec_pkg.sv
// Shared constants and types for the R-type execute/write-back unit.
package mips_exec_pkg;

  // Opcode field value for all R-type instructions.
  localparam logic [5:0] OP_RTYPE = 6'd0;

  // Supported funct codes.
  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_SRA   = 6'd3;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_ADDU  = 6'd33;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SUBU  = 6'd35;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_XOR   = 6'd38;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLTU  = 6'd43;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    WB
  } state_e;

  // Internal ALU operation, decoded from op/funct.
  typedef enum logic [4:0] {
    ALU_ADD,
    ALU_ADDU,
    ALU_SUB,
    ALU_SUBU,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_MULTU,
    ALU_MFHI,
    ALU_MFLO,
    ALU_ILLEGAL
  } alu_op_e;

  // Map an instruction's op/funct pair to an ALU operation.
  function automatic alu_op_e decode_op(input logic [5:0] op, input logic [5:0] funct);
    alu_op_e res;
    res = ALU_ILLEGAL;
    if (op == OP_RTYPE) begin
      case (funct)
        F_ADD:   res = ALU_ADD;
        F_ADDU:  res = ALU_ADDU;
        F_SUB:   res = ALU_SUB;
        F_SUBU:  res = ALU_SUBU;
        F_AND:   res = ALU_AND;
        F_OR:    res = ALU_OR;
        F_XOR:   res = ALU_XOR;
        F_NOR:   res = ALU_NOR;
        F_SLT:   res = ALU_SLT;
        F_SLTU:  res = ALU_SLTU;
        F_SLL:   res = ALU_SLL;
        F_SRL:   res = ALU_SRL;
        F_SRA:   res = ALU_SRA;
        F_MULTU: res = ALU_MULTU;
        F_MFHI:  res = ALU_MFHI;
        F_MFLO:  res = ALU_MFLO;
        default: res = ALU_ILLEGAL;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/mips_mult_seq.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle,
// XLEN cycles per product.
module mips_mult_seq #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2*XLEN-1:0] product_o
);

  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic [XLEN-1:0]   mcand_q;
  // Upper half accumulates partial sums; lower half holds the unconsumed
  // multiplier bits, which shift out as the product shifts in.
  logic [2*XLEN-1:0] prod_q;

  logic [XLEN-1:0]   addend_d;
  logic [XLEN:0]     sum_d;

  assign addend_d = prod_q[0] ? mcand_q : '0;
  assign sum_d    = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, addend_d};

  assign busy_o    = busy_q;
  // High during the final step; product_o is complete from the next cycle.
  assign done_o    = busy_q && (cnt_q == CW'(1));
  assign product_o = prod_q;

  // Load operands on start, then perform one add-and-shift step per cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (busy_q) begin
      prod_q <= {sum_d, prod_q[XLEN-1:1]};
      cnt_q  <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_q <= 1'b0;
      end
    end else if (start_i) begin
      mcand_q <= a_i;
      prod_q  <= {{XLEN{1'b0}}, b_i};
      cnt_q   <= CW'(XLEN);
      busy_q  <= 1'b1;
    end
  end

endmodule

// File: rtl/mips_rtype_exec.sv
// Sequential execute/write-back unit for MIPS R-type instructions:
// writable register file, ALU with shifts and compares, and an iterative
// MULTU into HI/LO.
module mips_rtype_exec
  import mips_exec_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            ins_valid,
  output logic            ins_ready,
  input  logic [31:0]     ins_word,
  output logic            done,
  output logic            wb_we,
  output logic [AW-1:0]   wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            ovf,
  output logic            illegal,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  state_e          state_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic            is_multu_q;

  logic            done_q;
  logic            wb_we_q;
  logic [AW-1:0]   wb_addr_q;
  logic [XLEN-1:0] wb_data_q;
  logic            ovf_q;
  logic            illegal_q;

  // Instruction fields; register addresses keep only their low AW bits.
  logic [5:0]      op_f;
  logic [5:0]      funct_f;
  logic [4:0]      shamt_f;
  logic [AW-1:0]   rs_a;
  logic [AW-1:0]   rt_a;
  logic [AW-1:0]   rd_a;

  assign op_f    = ir_q[31:26];
  assign rs_a    = ir_q[21 +: AW];
  assign rt_a    = ir_q[16 +: AW];
  assign rd_a    = ir_q[11 +: AW];
  assign shamt_f = ir_q[10:6];
  assign funct_f = ir_q[5:0];

  alu_op_e         alu_op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic [31:0]     sh_amt;
  logic [XLEN-1:0] result_d;
  logic            ovf_d;

  assign alu_op = decode_op(op_f, funct_f);
  // Register 0 is never written, so reading it always yields zero.
  assign rs_val = regs_q[rs_a];
  assign rt_val = regs_q[rt_a];
  assign sh_amt = 32'(shamt_f) % 32'(XLEN);

  assign ins_ready = (state_q == IDLE);
  assign done      = done_q;
  assign wb_we     = wb_we_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_data  = regs_q[dbg_addr];

  logic              mult_start;
  logic              mult_busy;
  logic              mult_done;
  logic [2*XLEN-1:0] mult_product;

  // The multiplier captures its operands as the sequencer leaves EXEC.
  assign mult_start = (state_q == EXEC) && (alu_op == ALU_MULTU) && !mult_busy;

  mips_mult_seq #(
    .XLEN (XLEN)
  ) u_mult (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .start_i   (mult_start),
    .a_i       (rs_val),
    .b_i       (rt_val),
    .busy_o    (mult_busy),
    .done_o    (mult_done),
    .product_o (mult_product)
  );

  // Single-cycle ALU: result and signed-overflow flag for the latched instruction.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and infers a latch; blocking '=' lets later lines read result_d.
    result_d = '0;
    ovf_d    = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        result_d = rs_val + rt_val;
        ovf_d    = (rs_val[XLEN-1] == rt_val[XLEN-1]) &&
                   (result_d[XLEN-1] != rs_val[XLEN-1]);
      end
      ALU_ADDU: result_d = rs_val + rt_val;
      ALU_SUB: begin
        result_d = rs_val - rt_val;
        ovf_d    = (rs_val[XLEN-1] != rt_val[XLEN-1]) &&
                   (result_d[XLEN-1] != rs_val[XLEN-1]);
      end
      ALU_SUBU: result_d = rs_val - rt_val;
      ALU_AND:  result_d = rs_val & rt_val;
      ALU_OR:   result_d = rs_val | rt_val;
      ALU_XOR:  result_d = rs_val ^ rt_val;
      ALU_NOR:  result_d = ~(rs_val | rt_val);
      ALU_SLT:  result_d = {{(XLEN-1){1'b0}}, ($signed(rs_val) < $signed(rt_val))};
      ALU_SLTU: result_d = {{(XLEN-1){1'b0}}, (rs_val < rt_val)};
      ALU_SLL:  result_d = rt_val << sh_amt;
      ALU_SRL:  result_d = rt_val >> sh_amt;
      ALU_SRA:  result_d = XLEN'($signed(rt_val) >>> sh_amt);
      ALU_MFHI: result_d = hi_q;
      ALU_MFLO: result_d = lo_q;
      default:  result_d = '0;
    endcase
  end

  // Sequencer: latch, execute, optionally multiply, then retire and commit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      ir_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_multu_q <= 1'b0;
      done_q     <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      ovf_q      <= 1'b0;
      illegal_q  <= 1'b0;
      // NOTE: the register file is architecturally cleared by reset, so the
      // array is reset here rather than left to power-up contents.
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (ins_valid) begin
            ir_q    <= ins_word;
            state_q <= EXEC;
          end
        end

        EXEC: begin
          is_multu_q <= (alu_op == ALU_MULTU);
          if (alu_op == ALU_MULTU) begin
            state_q <= MUL;
          end else begin
            state_q <= WB;
            done_q  <= 1'b1;
            if (alu_op == ALU_ILLEGAL) begin
              illegal_q <= 1'b1;
            end else if (ovf_d) begin
              ovf_q     <= 1'b1;
              wb_addr_q <= rd_a;
              wb_data_q <= result_d;
            end else begin
              wb_we_q   <= 1'b1;
              wb_addr_q <= rd_a;
              wb_data_q <= result_d;
            end
          end
        end

        MUL: begin
          if (mult_done) begin
            state_q <= WB;
            done_q  <= 1'b1;
          end
        end

        WB: begin
          if (wb_we_q && (wb_addr_q != '0)) begin
            regs_q[wb_addr_q] <= wb_data_q;
          end
          if (is_multu_q) begin
            hi_q <= mult_product[2*XLEN-1:XLEN];
            lo_q <= mult_product[XLEN-1:0];
          end
          is_multu_q <= 1'b0;
          done_q     <= 1'b0;
          wb_we_q    <= 1'b0;
          wb_addr_q  <= '0;
          wb_data_q  <= '0;
          ovf_q      <= 1'b0;
          illegal_q  <= 1'b0;
          state_q    <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_rtype_exec.sv
// Self-checking bench for mips_rtype_exec: table of instruction vectors with
// literal expectations, a retirement scoreboard, and hand-written sequences
// for latency, MULTU and reset-during-multiply.
module tb_mips_rtype_exec;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int AW     = $clog2(NREGS);
  localparam int PERIOD = 10;

  localparam logic [5:0] T_SLL = 6'd0,  T_SRL = 6'd2,  T_SRA = 6'd3;
  localparam logic [5:0] T_MFHI = 6'd16, T_MFLO = 6'd18, T_MULTU = 6'd25;
  localparam logic [5:0] T_ADD = 6'd32, T_ADDU = 6'd33, T_SUB = 6'd34, T_SUBU = 6'd35;
  localparam logic [5:0] T_AND = 6'd36, T_OR = 6'd37, T_XOR = 6'd38, T_NOR = 6'd39;
  localparam logic [5:0] T_SLT = 6'd42, T_SLTU = 6'd43;

  logic            CLK;
  logic            RESET;
  logic            ins_valid;
  logic            ins_ready;
  logic [31:0]     ins_word;
  logic            done;
  logic            wb_we;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            ovf;
  logic            illegal;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_data;

  mips_rtype_exec #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .ins_word  (ins_word),
    .done      (done),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .ovf       (ovf),
    .illegal   (illegal),
    .hi        (hi),
    .lo        (lo),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial CLK = 1'b0;
  always #(PERIOD/2) CLK = ~CLK;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ovf;
    logic        ill;
    longint      t_done;
  } exp_t;

  typedef struct {
    logic [31:0] word;
    exp_t        e;
    logic [4:0]  chk_reg;
    logic [31:0] chk_val;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {6'd0, rs, rt, rd, sh, f};
  endfunction

  function automatic exp_t mke(input string nm, input logic we, input logic [4:0] a,
                               input logic [31:0] d, input logic ov, input logic il);
    exp_t e;
    e.name = nm; e.we = we; e.addr = a; e.data = d; e.ovf = ov; e.ill = il; e.t_done = 0;
    return e;
  endfunction

  function automatic vec_t mkv(input string nm, input logic [31:0] w, input logic we,
                               input logic [4:0] a, input logic [31:0] d, input logic ov,
                               input logic il, input logic [4:0] cr, input logic [31:0] cv);
    vec_t v;
    v.word = w; v.e = mke(nm, we, a, d, ov, il); v.chk_reg = cr; v.chk_val = cv;
    return v;
  endfunction

  // Retirement monitor: every done pulse must match the oldest expectation.
  always @(negedge CLK) begin : mon
    exp_t e;
    if (!RESET && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(done), 64'(0));
      end else begin
        e = sb.pop_front();
        check({e.name, "_time"}, 64'($time), 64'(e.t_done));
        check({e.name, "_we"}, 64'(wb_we), 64'(e.we));
        check({e.name, "_ovf"}, 64'(ovf), 64'(e.ovf));
        check({e.name, "_ill"}, 64'(illegal), 64'(e.ill));
        if (e.we) begin
          check({e.name, "_addr"}, 64'(wb_addr), 64'(e.addr));
          check({e.name, "_data"}, 64'(wb_data), 64'(e.data));
        end
      end
    end
  end

  // Wait for ready, present one word, record when its done pulse is due.
  task automatic issue(input logic [31:0] w, input exp_t e, input int lat);
    int n;
    n = 0;
    @(negedge CLK);
    while (!ins_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!ins_ready) begin
      check({e.name, "_ready_timeout"}, 64'(ins_ready), 64'(1));
      return;
    end
    ins_word  = w;
    ins_valid = 1'b1;
    @(posedge CLK);
    e.t_done = longint'($time) + longint'(lat * PERIOD + PERIOD / 2);
    sb.push_back(e);
    #1;
    ins_valid = 1'b0;
    ins_word  = $urandom();
  endtask

  // Wait until all issued instructions retired and their writes committed.
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'(0));
    @(negedge CLK);
  endtask

  task automatic apply(input vec_t v);
    issue(v.word, v.e, 1);
    drain();
    dbg_addr = v.chk_reg;
    #1;
    check({v.e.name, "_reg"}, 64'(dbg_data), 64'(v.chk_val));
  endtask

  task automatic run_mul(input string nm, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int          bad;
    p = {32'd0, a} * {32'd0, b};
    issue(rtype(T_MULTU, ra, rb, 5'd0, 5'd0), mke(nm, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0), 1 + XLEN);
    bad = 0;
    for (int i = 0; i <= XLEN + 1; i++) begin
      @(negedge CLK);
      if (ins_ready) bad++;
    end
    check({nm, "_busy"}, 64'(bad), 64'(0));
    @(negedge CLK);
    check({nm, "_hi"}, 64'(hi), 64'(p[63:32]));
    check({nm, "_lo"}, 64'(lo), 64'(p[31:0]));
    check({nm, "_ready"}, 64'(ins_ready), 64'(1));
  endtask

  initial begin : watchdog
    #(20000 * PERIOD);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int cnt;
    RESET     = 1'b1;
    ins_valid = 1'b0;
    ins_word  = '0;
    dbg_addr  = '0;
    repeat (2) @(negedge CLK);
    check("rst_ready", 64'(ins_ready), 64'(1));
    check("rst_done", 64'(done), 64'(0));
    check("rst_we", 64'(wb_we), 64'(0));
    check("rst_flags", 64'({ovf, illegal}), 64'(0));
    check("rst_wb_addr", 64'(wb_addr), 64'(0));
    check("rst_wb_data", 64'(wb_data), 64'(0));
    check("rst_hilo", {hi, lo}, 64'(0));
    RESET = 1'b0;

    // name, word, we, addr, data, ovf, illegal, check reg, check value
    vecs.push_back(mkv("nor_ones", rtype(T_NOR, 0, 0, 31, 0), 1, 31, 32'hFFFFFFFF, 0, 0, 31, 32'hFFFFFFFF));
    vecs.push_back(mkv("subu_one", rtype(T_SUBU, 0, 31, 30, 0), 1, 30, 32'h1, 0, 0, 30, 32'h1));
    vecs.push_back(mkv("addu_r1a", rtype(T_ADDU, 30, 30, 1, 0), 1, 1, 32'h2, 0, 0, 1, 32'h2));
    vecs.push_back(mkv("addu_r1b", rtype(T_ADDU, 1, 30, 1, 0), 1, 1, 32'h3, 0, 0, 1, 32'h3));
    vecs.push_back(mkv("sll_r2", rtype(T_SLL, 0, 30, 2, 2), 1, 2, 32'h4, 0, 0, 2, 32'h4));
    vecs.push_back(mkv("add_r3", rtype(T_ADD, 1, 2, 3, 0), 1, 3, 32'h7, 0, 0, 3, 32'h7));
    vecs.push_back(mkv("srl_max", rtype(T_SRL, 0, 31, 4, 1), 1, 4, 32'h7FFFFFFF, 0, 0, 4, 32'h7FFFFFFF));
    vecs.push_back(mkv("addu_r5", rtype(T_ADDU, 0, 30, 5, 0), 1, 5, 32'h1, 0, 0, 5, 32'h1));
    vecs.push_back(mkv("add_ovf", rtype(T_ADD, 4, 5, 6, 0), 0, 6, 32'h0, 1, 0, 6, 32'h0));
    vecs.push_back(mkv("addu_wrap", rtype(T_ADDU, 4, 5, 6, 0), 1, 6, 32'h80000000, 0, 0, 6, 32'h80000000));
    vecs.push_back(mkv("slt_neg", rtype(T_SLT, 31, 5, 9, 0), 1, 9, 32'h1, 0, 0, 9, 32'h1));
    vecs.push_back(mkv("sltu_big", rtype(T_SLTU, 31, 5, 10, 0), 1, 10, 32'h0, 0, 0, 10, 32'h0));
    vecs.push_back(mkv("slt_pos", rtype(T_SLT, 5, 31, 21, 0), 1, 21, 32'h0, 0, 0, 21, 32'h0));
    vecs.push_back(mkv("sltu_small", rtype(T_SLTU, 5, 31, 22, 0), 1, 22, 32'h1, 0, 0, 22, 32'h1));
    vecs.push_back(mkv("sra_4", rtype(T_SRA, 0, 6, 11, 4), 1, 11, 32'hF8000000, 0, 0, 11, 32'hF8000000));
    vecs.push_back(mkv("srl_4", rtype(T_SRL, 0, 6, 12, 4), 1, 12, 32'h08000000, 0, 0, 12, 32'h08000000));
    vecs.push_back(mkv("sub_neg", rtype(T_SUB, 1, 2, 13, 0), 1, 13, 32'hFFFFFFFF, 0, 0, 13, 32'hFFFFFFFF));
    vecs.push_back(mkv("sub_ovf", rtype(T_SUB, 6, 5, 14, 0), 0, 14, 32'h0, 1, 0, 14, 32'h0));
    vecs.push_back(mkv("subu_wrap", rtype(T_SUBU, 6, 5, 14, 0), 1, 14, 32'h7FFFFFFF, 0, 0, 14, 32'h7FFFFFFF));
    vecs.push_back(mkv("or", rtype(T_OR, 1, 2, 15, 0), 1, 15, 32'h7, 0, 0, 15, 32'h7));
    vecs.push_back(mkv("and", rtype(T_AND, 31, 1, 16, 0), 1, 16, 32'h3, 0, 0, 16, 32'h3));
    vecs.push_back(mkv("xor", rtype(T_XOR, 1, 3, 17, 0), 1, 17, 32'h4, 0, 0, 17, 32'h4));
    vecs.push_back(mkv("nor", rtype(T_NOR, 1, 2, 18, 0), 1, 18, 32'hFFFFFFF8, 0, 0, 18, 32'hFFFFFFF8));
    vecs.push_back(mkv("sll_31", rtype(T_SLL, 0, 30, 19, 31), 1, 19, 32'h80000000, 0, 0, 19, 32'h80000000));
    vecs.push_back(mkv("sra_31n", rtype(T_SRA, 0, 31, 23, 31), 1, 23, 32'hFFFFFFFF, 0, 0, 23, 32'hFFFFFFFF));
    vecs.push_back(mkv("sra_31p", rtype(T_SRA, 0, 4, 24, 31), 1, 24, 32'h0, 0, 0, 24, 32'h0));
    vecs.push_back(mkv("add_negneg", rtype(T_ADD, 31, 31, 25, 0), 1, 25, 32'hFFFFFFFE, 0, 0, 25, 32'hFFFFFFFE));
    vecs.push_back(mkv("add_ovf_neg", rtype(T_ADD, 6, 6, 26, 0), 0, 26, 32'h0, 1, 0, 26, 32'h0));
    vecs.push_back(mkv("rd_zero", rtype(T_ADDU, 1, 2, 0, 0), 1, 0, 32'h7, 0, 0, 0, 32'h0));
    vecs.push_back(mkv("ill_funct13", rtype(6'd13, 1, 2, 3, 0), 0, 0, 32'h0, 0, 1, 3, 32'h7));
    vecs.push_back(mkv("ill_op8", {6'd8, 5'd1, 5'd2, 5'd3, 5'd0, 6'd32}, 0, 0, 32'h0, 0, 1, 3, 32'h7));
    vecs.push_back(mkv("ill_funct1", rtype(6'd1, 1, 2, 3, 0), 0, 0, 32'h0, 0, 1, 3, 32'h7));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Latency and throughput of a simple op: ready low in EXEC and WB, the
    // write becomes visible only once the unit is back in IDLE.
    dbg_addr = 5'd27;
    issue(rtype(T_ADD, 1, 2, 27, 0), mke("lat_add", 1, 27, 32'h7, 0, 0), 1);
    @(negedge CLK);
    check("lat_exec_ready", 64'(ins_ready), 64'(0));
    @(negedge CLK);
    check("lat_wb_ready", 64'(ins_ready), 64'(0));
    check("lat_wb_old", 64'(dbg_data), 64'(0));
    @(negedge CLK);
    check("lat_idle_ready", 64'(ins_ready), 64'(1));
    check("lat_visible", 64'(dbg_data), 64'(7));

    // Iterative multiply into HI/LO, then moves out of HI/LO.
    run_mul("mul_max", 5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF);
    apply(mkv("mfhi", rtype(T_MFHI, 0, 0, 7, 0), 1, 7, 32'hFFFFFFFE, 0, 0, 7, 32'hFFFFFFFE));
    apply(mkv("mflo", rtype(T_MFLO, 0, 0, 20, 0), 1, 20, 32'h1, 0, 0, 20, 32'h1));
    run_mul("mul_small", 5'd1, 5'd2, 32'h3, 32'h4);
    run_mul("mul_mixed", 5'd4, 5'd3, 32'h7FFFFFFF, 32'h7);

    // Reset in the middle of a multiply: everything clears, nothing retires.
    issue(rtype(T_MULTU, 31, 31, 0, 0), mke("mul_rst", 0, 0, 32'h0, 0, 0), 1 + XLEN);
    repeat (10) @(negedge CLK);
    RESET = 1'b1;
    dbg_addr = 5'd3;
    #1;
    check("midrst_ready", 64'(ins_ready), 64'(1));
    check("midrst_hilo", {hi, lo}, 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_reg", 64'(dbg_data), 64'(0));
    sb.delete();
    @(negedge CLK);
    RESET = 1'b0;
    cnt = 0;
    for (int i = 0; i < XLEN + 4; i++) begin
      @(negedge CLK);
      if (done) cnt++;
    end
    check("midrst_no_done", 64'(cnt), 64'(0));
    check("midrst_hilo_hold", {hi, lo}, 64'(0));

    apply(mkv("post_nor", rtype(T_NOR, 0, 0, 31, 0), 1, 31, 32'hFFFFFFFF, 0, 0, 31, 32'hFFFFFFFF));
    apply(mkv("post_add", rtype(T_ADD, 31, 31, 3, 0), 1, 3, 32'hFFFFFFFE, 0, 0, 3, 32'hFFFFFFFE));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
